// File: rtl/demux2_pkg.sv
// Shared types for the 2-way stream demux: FSM state encoding and route constants.
package demux2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic ROUTE_OUT0 = 1'b0;
  localparam logic ROUTE_OUT1 = 1'b1;

endpackage

// File: rtl/demux2_stream_slot.sv
// One-entry registered output slot; load and drain may coincide for full throughput.
// Data/last only change on load, so they stay stable while valid && !ready.
module stream_slot #(
  parameter int DWIDTH = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DWIDTH-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              fire,
  output logic              free
);

  logic              valid_q, valid_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign fire = valid_q && out_ready;
  assign free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/demux2_stream.sv
// 1-to-2 packet router: route taken from sel on the first beat, held until the last beat.
// Optional per-output handshake counters when DEMUX2_STREAM_CNT_EN is defined.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int DWIDTH = 6
`ifdef DEMUX2_STREAM_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic                 in_last,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [DWIDTH-1:0]    out0_data,
  output logic                 out0_last,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [DWIDTH-1:0]    out1_data,
  output logic                 out1_last,
`ifdef DEMUX2_STREAM_CNT_EN
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
`endif
  output logic                 busy
);

  state_t state_q, state_d;
  logic   route_q, route_d;
  logic   busy_q, busy_d;
  logic   eff_route, accept;
  logic   free0, free1, fire0, fire1;

  // In IDLE the route follows sel directly so a first beat needs no setup cycle.
  assign eff_route = (state_q == LOCK) ? route_q : sel;
  assign in_ready  = (eff_route == ROUTE_OUT1) ? free1 : free0;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      IDLE: if (accept && !in_last) begin
        state_d = LOCK;
        route_d = sel;
      end
      LOCK: if (accept && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOCK);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      route_q <= ROUTE_OUT0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  stream_slot #(.DWIDTH(DWIDTH)) u_slot0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (accept && (eff_route == ROUTE_OUT0)),
    .load_data (in_data),
    .load_last (in_last),
    .out_ready (out0_ready),
    .out_valid (out0_valid),
    .out_data  (out0_data),
    .out_last  (out0_last),
    .fire      (fire0),
    .free      (free0)
  );

  stream_slot #(.DWIDTH(DWIDTH)) u_slot1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (accept && (eff_route == ROUTE_OUT1)),
    .load_data (in_data),
    .load_last (in_last),
    .out_ready (out1_ready),
    .out_valid (out1_valid),
    .out_data  (out1_data),
    .out_last  (out1_last),
    .fire      (fire1),
    .free      (free1)
  );

`ifdef DEMUX2_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Free-running wrap: no saturation on overflow.
  always_comb begin
    cnt0_d = cnt0_q + {{(CNT_WIDTH-1){1'b0}}, fire0};
    cnt1_d = cnt1_q + {{(CNT_WIDTH-1){1'b0}}, fire1};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream: vector table for routing/lock/backpressure,
// hand-written sequences for async reset mid-packet and the optional counters.
module tb_demux2_stream;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sel, in_valid, in_last;
  logic [5:0] in_data;
  logic       in_ready;
  logic       out0_valid, out0_ready, out0_last;
  logic [5:0] out0_data;
  logic       out1_valid, out1_ready, out1_last;
  logic [5:0] out1_data;
  logic       busy;
`ifdef DEMUX2_STREAM_CNT_EN
  logic [1:0] cnt0, cnt1;
`endif

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  demux2_stream #(
    .DWIDTH(6)
`ifdef DEMUX2_STREAM_CNT_EN
    , .CNT_WIDTH(2)
`endif
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
`ifdef DEMUX2_STREAM_CNT_EN
    .cnt0       (cnt0),
    .cnt1       (cnt1),
`endif
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       sel, vld;
    logic [5:0] dat;
    logic       lst, r0, r1;
    logic       e_rdy, e_v0;
    logic [5:0] e_d0;
    logic       e_l0, e_v1;
    logic [5:0] e_d1;
    logic       e_l1, e_busy;
  } vec_t;

  vec_t vt [13];

  task automatic check_outs(input string tag, input logic v0, input logic [5:0] d0, input logic l0,
                            input logic v1, input logic [5:0] d1, input logic l1, input logic b);
    chk({tag, ".out0_valid"}, 16'(out0_valid), 16'(v0));
    chk({tag, ".out0_data"},  16'(out0_data),  16'(d0));
    chk({tag, ".out0_last"},  16'(out0_last),  16'(l0));
    chk({tag, ".out1_valid"}, 16'(out1_valid), 16'(v1));
    chk({tag, ".out1_data"},  16'(out1_data),  16'(d1));
    chk({tag, ".out1_last"},  16'(out1_last),  16'(l1));
    chk({tag, ".busy"},       16'(busy),       16'(b));
  endtask

  initial begin
    //          sel   vld   dat    lst   r0    r1  | rdy   v0    d0     l0    v1    d1     l1    busy
    // single-beat alternating packets
    vt[0]  = '{1'b0, 1'b1, 6'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h01, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 6'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h01, 1'b1, 1'b1, 6'h02, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 6'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h03, 1'b1, 1'b0, 6'h02, 1'b1, 1'b0};
    // packet lock: sel toggles after the first beat and is ignored
    vt[3]  = '{1'b1, 1'b1, 6'h0A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h03, 1'b1, 1'b1, 6'h0A, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 6'h0B, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h03, 1'b1, 1'b1, 6'h0B, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 6'h0C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h03, 1'b1, 1'b1, 6'h0C, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h03, 1'b1, 1'b0, 6'h0C, 1'b1, 1'b0};
    // independent backpressure: out0 stalled holding 11
    vt[7]  = '{1'b0, 1'b1, 6'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h11, 1'b1, 1'b0, 6'h0C, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 6'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h11, 1'b1, 1'b1, 6'h22, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 6'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h11, 1'b1, 1'b0, 6'h22, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 6'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'h11, 1'b1, 1'b0, 6'h22, 1'b1, 1'b0};
    // drain and refill in the same cycle
    vt[11] = '{1'b0, 1'b1, 6'h3F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h3F, 1'b1, 1'b0, 6'h22, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h3F, 1'b1, 1'b0, 6'h22, 1'b1, 1'b0};

    reset_n = 1'b0;
    sel = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #1;
    check_outs("reset", 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      sel = vt[i].sel; in_valid = vt[i].vld; in_data = vt[i].dat; in_last = vt[i].lst;
      out0_ready = vt[i].r0; out1_ready = vt[i].r1;
      #1;
      chk($sformatf("v%0d.in_ready", i), 16'(in_ready), 16'(vt[i].e_rdy));
      @(posedge clock); #1;
      check_outs($sformatf("v%0d", i), vt[i].e_v0, vt[i].e_d0, vt[i].e_l0,
                 vt[i].e_v1, vt[i].e_d1, vt[i].e_l1, vt[i].e_busy);
    end

    // reset in the middle of a packet routed to out1
    sel = 1'b1; in_valid = 1'b1; in_data = 6'h15; in_last = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b0;
    @(posedge clock); #1;
    chk("midpkt.out1_valid", 16'(out1_valid), 16'd1);
    chk("midpkt.busy", 16'(busy), 16'd1);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst.out1_valid", 16'(out1_valid), 16'd0);
    chk("arst.busy", 16'(busy), 16'd0);
    chk("arst.out1_data", 16'(out1_data), 16'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    sel = 1'b0; in_valid = 1'b1; in_data = 6'h05; in_last = 1'b1;
    out1_ready = 1'b1;
    #1;
    chk("postrst.in_ready", 16'(in_ready), 16'd1);
    @(posedge clock); #1;
    check_outs("postrst", 1'b1, 6'h05, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    in_valid = 1'b0;

`ifdef DEMUX2_STREAM_CNT_EN
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
      reset_n = 1'b0;
      #1;
      chk("cnt.reset0", 16'(cnt0), 16'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      out0_ready = 1'b1; out1_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
        sel = 1'b0; in_valid = 1'b1; in_data = 6'(k); in_last = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        chk($sformatf("cnt0[%0d]", k), 16'(cnt0), 16'(exp_cnt[k]));
        chk($sformatf("cnt1[%0d]", k), 16'(cnt1), 16'd0);
      end
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 1-to-2 stream router: steers a valid/ready input stream to one of two outputs, selected per packet by `sel`.
- Each output has a one-entry registered slot.
- The route is latched on the first beat of a packet and held until the beat with `in_last` is accepted.
- Sits upstream of pairs of consumers that are later recombined by Mux2-style selection.

Parameters:
- DWIDTH, 6, data width of input and both outputs.
- CNT_WIDTH, 16, width of the per-output beat counters (used only with the optional feature).

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- sel  input  1  route for a new packet: 0 selects out0, 1 selects out1; sampled only on the first beat
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  DWIDTH  input beat data
- in_last  input  1  final beat of a packet
- out0_valid  output  1  out0 slot holds a beat
- out0_ready  input  1  out0 consumer ready
- out0_data  output  DWIDTH  out0 beat data
- out0_last  output  1  out0 beat is the final beat of its packet
- out1_valid, out1_ready, out1_data, out1_last: same as the out0 set, for out1
- busy  output  1  a packet route is locked (LOCK state)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State = IDLE, route = 0.
  - out0_valid, out1_valid, busy = 0.
  - out*_data, out*_last = 0.
  - Counters = 0.
- States:
  - IDLE: no packet in progress; the route comes from `sel` combinationally.
  - LOCK: the route register holds the route of the current packet.
- Effective route: `sel` in IDLE, the route register in LOCK.
- Slot free condition, for slot k: !outk_valid || outk_ready (a drain and a fill in the same cycle is allowed, giving full throughput).
- in_ready = slot free for the effective route. It never depends on the non-selected slot.
- On accept (in_valid && in_ready):
  - Selected slot loads in_data and in_last; its valid is set next cycle.
  - Latency is exactly 1 cycle from input accept to outk_valid.
- Transitions:
  - IDLE, accept with in_last=0: route <= sel, go to LOCK.
  - IDLE, accept with in_last=1: single-beat packet, stay in IDLE.
  - LOCK, accept with in_last=1: go to IDLE.
  - All other cases: hold state.
- busy = (state == LOCK), registered.
- Slot clear: outk_valid goes to 0 on outk_valid && outk_ready with no same-cycle refill.
- Output stability: outk_data and outk_last are held stable while outk_valid && !outk_ready.
- `sel` changes while in LOCK are ignored. In IDLE, `sel` may change freely while in_valid=0.
- The two outputs are independent: out1 may drain while out0 stalls, and a stalled out0 does not block a new packet routed to out1.
- Back-to-back single-beat packets to alternating outputs sustain 1 beat/cycle when both consumers are ready.
- Data width is unchanged; there is no arithmetic on data.

Optional Feature:
- Macro: DEMUX2_STREAM_CNT_EN.
- When defined:
  - Adds output ports cnt0 and cnt1, each CNT_WIDTH bits.
  - cntk increments by 1 on each outk handshake (outk_valid && outk_ready).
  - Wraps from all-ones to 0 with no saturation.
  - Reset value is 0.
- When undefined: no counter ports or logic exist; all other behaviour is identical.

Decomposition:
- Shared package demux2_pkg:
  - state typedef (IDLE=1'b0, LOCK=1'b1);
  - route constants ROUTE_OUT0=1'b0, ROUTE_OUT1=1'b1.
- Sub-module stream_slot (DWIDTH): one-entry output register with valid/ready, load, data, last and fire indication; instantiated twice. The counter, if enabled, is built on the slot's fire output.

Test Plan:
- Reset mid-packet:
  - Stimulus: in_valid=1, sel=1, in_data=6'h15, in_last=0 accepted, then reset_n=0 asynchronously.
  - Required: out1_valid=0 and busy=0 immediately; after release, sel=0 routes to out0.
- Single-beat alternating packets:
  - Stimulus: both outputs ready; beats 6'h01 (sel=0), 6'h02 (sel=1), 6'h03 (sel=0), each with in_last=1.
  - Required: out0 shows 01 then 03, out1 shows 02, each 1 cycle after accept; in_ready stays 1.
- Packet lock:
  - Stimulus: sel=1 on first beat 6'h0A; sel toggles to 0 on beats 6'h0B and 6'h0C (last).
  - Required: all three beats on out1 with out1_last only on 6'h0C; busy=1 from after the first beat until after the last beat.
- Independent backpressure:
  - Stimulus: out0_ready=0 with out0 holding 6'h11; then a sel=1 beat 6'h22.
  - Required: 6'h22 is accepted and appears on out1; out0_data is held at 6'h11; in_ready=0 for any sel=0 beat until out0_ready=1.
- Full-throughput stall/refill:
  - Stimulus: out0 slot full; out0_ready=1 in the same cycle as a new sel=0 beat 6'h3F.
  - Required: in_ready=1; the slot shows 6'h3F the next cycle with no bubble.
- Counters, with DEMUX2_STREAM_CNT_EN defined and CNT_WIDTH=2:
  - Stimulus: 5 handshakes on out0.
  - Required: cnt0 sequence 1,2,3,0,1; cnt1 stays 0.
